// File: rtl/led_matrix_pkg.sv
// Shared sizes, frame type and scan-phase encoding for the LED matrix back end.
package led_matrix_pkg;

   localparam int NUM_ROWS = 16;
   localparam int NUM_COLS = 16;

   typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] frame_t;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// Row scan sequencer: alternates a dark gap and a lit dwell per row, walking rows 0..15.
module scan_timer
   import led_matrix_pkg::*;
#(
   parameter int CLKS_PER_ROW = 8,
   parameter int BLANK_CLKS   = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       en_i,
   output logic [3:0] row_o,
   output logic       on_o,
   output logic       cap_o
);

   localparam int MAXD = (CLKS_PER_ROW > BLANK_CLKS) ? CLKS_PER_ROW : BLANK_CLKS;
   localparam int DW   = $clog2(MAXD + 1);
   localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CLKS - 1);
   localparam logic [DW-1:0] ON_LAST    = DW'(CLKS_PER_ROW - 1);

   scan_state_e   state_q;
   logic [3:0]    row_q;
   logic [DW-1:0] dwell_q;

   // Dropping en parks the scan at the start of row 0's blank so a re-enable starts a clean frame.
   always_ff @(posedge clk_i) begin
      if (reset_i || !en_i) begin
         state_q <= BLANK;
         row_q   <= '0;
         dwell_q <= '0;
      end else begin
         case (state_q)
            BLANK: begin
               if (dwell_q == BLANK_LAST) begin
                  state_q <= ON;
                  dwell_q <= '0;
               end else begin
                  dwell_q <= dwell_q + DW'(1);
               end
            end
            ON: begin
               if (dwell_q == ON_LAST) begin
                  state_q <= BLANK;
                  row_q   <= row_q + 4'd1;
                  dwell_q <= '0;
               end else begin
                  dwell_q <= dwell_q + DW'(1);
               end
            end
            default: state_q <= BLANK;
         endcase
      end
   end

   assign row_o = row_q;
   assign on_o  = (state_q == ON);
   assign cap_o = (state_q == BLANK) && (row_q == 4'd0) && (dwell_q == BLANK_LAST);

endmodule

// File: rtl/led_matrix_driver.sv
// Row-multiplexed LED board driver with a per-frame shadow copy of the controller's pixels.
module led_matrix_driver
   import led_matrix_pkg::*;
#(
   parameter int CLKS_PER_ROW = 8,
   parameter int BLANK_CLKS   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [15:0][15:0]  RedPixels,
   input  logic [15:0][15:0]  GrnPixels,
   output logic [15:0]        RowSel,
   output logic [15:0]        RedCols,
   output logic [15:0]        GrnCols,
   output logic               FrameStart
);

   frame_t     red_q;
   frame_t     grn_q;
   logic [3:0] row;
   logic       on;
   logic       cap;

   scan_timer #(
      .CLKS_PER_ROW (CLKS_PER_ROW),
      .BLANK_CLKS   (BLANK_CLKS)
   ) u_timer (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (en),
      .row_o   (row),
      .on_o    (on),
      .cap_o   (cap)
   );

   // Whole-frame snapshot taken once per frame, so controller updates never tear a scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         red_q <= '0;
         grn_q <= '0;
      end else if (en && cap) begin
         red_q <= RedPixels;
         grn_q <= GrnPixels;
      end
   end

   always_comb begin
      RowSel  = '0;
      RedCols = '0;
      GrnCols = '0;
      if (on) begin
         RowSel[row] = 1'b1;
         RedCols     = red_q[row];
         GrnCols     = grn_q[row];
      end
   end

   assign FrameStart = cap;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Scoreboard bench: frame-position model predicts every output cycle; a negedge monitor compares.
module tb_led_matrix_driver;

   localparam int B  = 2;
   localparam int C  = 8;
   localparam int RL = B + C;
   localparam int P  = 16 * RL;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic [15:0][15:0] red;
   logic [15:0][15:0] grn;
   logic [15:0]       RowSel, RedCols, GrnCols;
   logic              FrameStart;

   always #5 clk = ~clk;

   led_matrix_driver #(.CLKS_PER_ROW(C), .BLANK_CLKS(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .RedPixels  (red),
      .GrnPixels  (grn),
      .RowSel     (RowSel),
      .RedCols    (RedCols),
      .GrnCols    (GrnCols),
      .FrameStart (FrameStart)
   );

   typedef struct {
      logic [15:0] rs;
      logic [15:0] rc;
      logic [15:0] gc;
      logic        fs;
      int          n;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;

   // Model: n = cycle number within the current scan epoch (1 = first blank cycle of row 0).
   int                n;
   logic [15:0][15:0] m_red, m_grn;

   function automatic exp_t predict(int nn);
      exp_t e;
      int   p, r, off;
      p     = (nn - 1) % P;
      r     = p / RL;
      off   = p % RL;
      e.rs  = '0;
      e.rc  = '0;
      e.gc  = '0;
      e.fs  = (r == 0) && (off == B - 1);
      e.n   = nn;
      if (off >= B) begin
         e.rs = 16'(1) << r;
         e.rc = m_red[r];
         e.gc = m_grn[r];
      end
      return e;
   endfunction

   function automatic int cur_row();
      return ((n - 1) % P) / RL;
   endfunction

   function automatic int cur_off();
      return ((n - 1) % P) % RL;
   endfunction

   task automatic cyc();
      q.push_back(predict(n));
      @(posedge clk);
      if (reset) begin
         n     = 1;
         m_red = '0;
         m_grn = '0;
      end else if (!en) begin
         n = 1;
      end else begin
         if ((n - 1) % P == B - 1) begin
            m_red = red;
            m_grn = grn;
         end
         n++;
      end
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp, input int nn);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at epoch cycle %0d: got %h expected %h", name, nn, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         me = q.pop_front();
         chk("RowSel",     RowSel,            me.rs,            me.n);
         chk("RedCols",    RedCols,           me.rc,            me.n);
         chk("GrnCols",    GrnCols,           me.gc,            me.n);
         chk("FrameStart", {15'd0, FrameStart}, {15'd0, me.fs}, me.n);
      end
   end

   initial begin
      int ri;
      reset = 1'b1;
      en    = 1'b0;
      red   = '0;
      grn   = '0;
      n     = 1;
      m_red = '0;
      m_grn = '0;
      @(posedge clk);
      #1;
      repeat (2) cyc();

      // Startup, wrap-around and tear-free capture over two frames.
      reset  = 1'b0;
      en     = 1'b1;
      red[0] = 16'h01C0;
      for (int k = 1; k <= 230; k++) begin
         if (k == 30) grn[5] = 16'hFFFF;
         cyc();
      end

      // en dropped during row 7 lit dwell.
      while (!(cur_row() == 7 && cur_off() >= B + 2)) cyc();
      en = 1'b0;
      repeat (5) cyc();
      en = 1'b1;
      repeat (30) cyc();

      // Reset during row 3 lit dwell with all-zero inputs.
      red = '0;
      grn = '0;
      while (!(cur_row() == 3 && cur_off() >= B + 1)) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (20) cyc();

      // Yellow pixels: red and green both driven on row 8.
      red[8] = 16'h8001;
      grn[8] = 16'h8001;
      reset  = 1'b1;
      cyc();
      reset  = 1'b0;
      repeat (100) cyc();

      // Random pixel traffic with occasional enable drops and resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(19) == 0) begin
            ri      = $urandom_range(15);
            red[ri] = 16'($urandom);
         end
         if ($urandom_range(19) == 0) begin
            ri      = $urandom_range(15);
            grn[ri] = 16'($urandom);
         end
         en    = ($urandom_range(99) < 3) ? 1'b0 : 1'b1;
         reset = ($urandom_range(499) == 0);
         cyc();
      end
      reset = 1'b0;
      en    = 1'b1;
      repeat (2) cyc();
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
